wb_stage: RTL and testbench

- Write-back stage of the five-stage pipeline. It sits directly downstream of the memory-access stage and latches the MEM->WB bus.
- Retires one instruction per cycle into the register file, the HI/LO registers and a minimal CP0 (STATUS, CAUSE, EPC).
- Handles SYSCALL/ERET by raising a pipeline cancel and a redirect PC toward fetch.
- Also drives the WB-stage forwarding and hazard signals back to EXE/ID.

---
 rtl/wb_stage.sv | 173 +++++++++++++++++
 tb/tb_wb_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: retires into the register file, HI/LO and a minimal CP0,
// and raises cancel plus a fetch redirect for SYSCALL/ERET.
module wb_stage #(
    parameter logic [31:0] EXC_ENTRY = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         MEM_over,
    input  logic [118:0] MEM_WB_bus,
    output logic         WB_allow_in,
    output logic         WB_over,
    output logic         rf_wen,
    output logic [4:0]   rf_wdest,
    output logic [31:0]  rf_wdata,
    output logic [4:0]   WB_wdest,
    output logic [4:0]   WB_to_EXEforeword_wdest,
    output logic [31:0]  WB_to_EXEforeword_wdata,
    output logic         exc_valid,
    output logic [31:0]  exc_pc,
    output logic         cancel,
    output logic [31:0]  HI_data,
    output logic [31:0]  LO_data,
    output logic [31:0]  WB_pc
);

    localparam logic [7:0]  ADDR_STATUS = 8'h60;
    localparam logic [7:0]  ADDR_CAUSE  = 8'h68;
    localparam logic [7:0]  ADDR_EPC    = 8'h70;
    localparam logic [31:0] STATUS_MASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_MASK  = 32'h0000_037C;

    logic         wb_valid_q, wb_valid_d;
    logic [118:0] bus_q, bus_d;
    logic [31:0]  hi_q, hi_d;
    logic [31:0]  lo_q, lo_d;
    logic [31:0]  epc_q, epc_d;
    logic [31:0]  status_q, status_d;
    logic [31:0]  cause_q, cause_d;

    logic         b_rf_wen;
    logic [4:0]   b_rf_wdest;
    logic [31:0]  b_mem_result;
    logic [31:0]  b_lo_result;
    logic         b_hi_write;
    logic         b_lo_write;
    logic         b_mfhi;
    logic         b_mflo;
    logic         b_mtc0;
    logic         b_mfc0;
    logic [7:0]   b_cp0_addr;
    logic         b_syscall;
    logic         b_eret;
    logic [31:0]  b_pc;
    logic         unused_bits;

    logic         commit;
    logic [31:0]  cp0_rdata;

    assign unused_bits  = bus_q[118];
    assign b_rf_wen     = bus_q[117];
    assign b_rf_wdest   = bus_q[116:112];
    assign b_mem_result = bus_q[111:80];
    assign b_lo_result  = bus_q[79:48];
    assign b_hi_write   = bus_q[47];
    assign b_lo_write   = bus_q[46];
    assign b_mfhi       = bus_q[45];
    assign b_mflo       = bus_q[44];
    assign b_mtc0       = bus_q[43];
    assign b_mfc0       = bus_q[42];
    assign b_cp0_addr   = bus_q[41:34];
    assign b_syscall    = bus_q[33];
    assign b_eret       = bus_q[32];
    assign b_pc         = bus_q[31:0];

    assign commit      = wb_valid_q & ~reset;
    assign WB_over     = wb_valid_q;
    assign WB_allow_in = ~wb_valid_q | WB_over;

    assign exc_valid = commit & (b_syscall | b_eret);
    assign cancel    = exc_valid;
    assign exc_pc    = exc_valid ? (b_eret ? epc_q : EXC_ENTRY) : 32'h0;

    always_comb begin
        cp0_rdata = 32'h0;
        case (b_cp0_addr)
            ADDR_STATUS: cp0_rdata = status_q;
            ADDR_CAUSE:  cp0_rdata = cause_q;
            ADDR_EPC:    cp0_rdata = epc_q;
            default:     cp0_rdata = 32'h0;
        endcase
    end

    // Reads see the pre-retire value of HI/LO/CP0; no same-cycle bypass.
    always_comb begin
        rf_wdata = b_mem_result;
        if (b_mfhi)
            rf_wdata = hi_q;
        else if (b_mflo)
            rf_wdata = lo_q;
        else if (b_mfc0)
            rf_wdata = cp0_rdata;
    end

    assign rf_wen   = commit & b_rf_wen;
    assign rf_wdest = b_rf_wdest;
    assign WB_wdest = rf_wdest & {5{wb_valid_q}};

    assign WB_to_EXEforeword_wdest = rf_wdest & {5{wb_valid_q}};
    assign WB_to_EXEforeword_wdata = rf_wdata & {32{wb_valid_q}};

    assign HI_data = hi_q;
    assign LO_data = lo_q;
    assign WB_pc   = b_pc;

    always_comb begin
        wb_valid_d = wb_valid_q;
        bus_d      = bus_q;
        if (WB_allow_in) begin
            wb_valid_d = MEM_over & ~cancel;
            bus_d      = MEM_WB_bus;
        end
    end

    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        epc_d    = epc_q;
        status_d = status_q;
        cause_d  = cause_q;
        if (commit) begin
            if (b_hi_write)
                hi_d = b_mem_result;
            if (b_lo_write)
                lo_d = b_lo_result;
            if (b_mtc0) begin
                case (b_cp0_addr)
                    ADDR_STATUS: status_d = b_mem_result & STATUS_MASK;
                    ADDR_CAUSE:  cause_d  = b_mem_result & CAUSE_MASK;
                    ADDR_EPC:    epc_d    = b_mem_result;
                    default:     ;
                endcase
            end
            if (b_syscall) begin
                epc_d       = b_pc;
                status_d[1] = 1'b1;
                cause_d[6:2] = 5'd8;
            end
            if (b_eret)
                status_d[1] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            bus_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            epc_q      <= '0;
            status_q   <= '0;
            cause_q    <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            bus_q      <= bus_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            epc_q      <= epc_d;
            status_q   <= status_d;
            cause_q    <= cause_d;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a vector table of retiring instructions
// followed by a hand-written reset-while-busy sequence.
module tb_wb_stage;

    logic         clk;
    logic         reset;
    logic         MEM_over;
    logic [118:0] MEM_WB_bus;
    logic         WB_allow_in;
    logic         WB_over;
    logic         rf_wen;
    logic [4:0]   rf_wdest;
    logic [31:0]  rf_wdata;
    logic [4:0]   WB_wdest;
    logic [4:0]   fwd_wdest;
    logic [31:0]  fwd_wdata;
    logic         exc_valid;
    logic [31:0]  exc_pc;
    logic         cancel;
    logic [31:0]  HI_data;
    logic [31:0]  LO_data;
    logic [31:0]  WB_pc;

    wb_stage #(.EXC_ENTRY(32'h0000_0000)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .MEM_over                (MEM_over),
        .MEM_WB_bus              (MEM_WB_bus),
        .WB_allow_in             (WB_allow_in),
        .WB_over                 (WB_over),
        .rf_wen                  (rf_wen),
        .rf_wdest                (rf_wdest),
        .rf_wdata                (rf_wdata),
        .WB_wdest                (WB_wdest),
        .WB_to_EXEforeword_wdest (fwd_wdest),
        .WB_to_EXEforeword_wdata (fwd_wdata),
        .exc_valid               (exc_valid),
        .exc_pc                  (exc_pc),
        .cancel                  (cancel),
        .HI_data                 (HI_data),
        .LO_data                 (LO_data),
        .WB_pc                   (WB_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] C_HW   = 6'b100000;
    localparam logic [5:0] C_LW   = 6'b010000;
    localparam logic [5:0] C_MFHI = 6'b001000;
    localparam logic [5:0] C_MFLO = 6'b000100;
    localparam logic [5:0] C_MTC0 = 6'b000010;
    localparam logic [5:0] C_MFC0 = 6'b000001;
    localparam logic [1:0] SE_SYS  = 2'b10;
    localparam logic [1:0] SE_ERET = 2'b01;
    localparam logic [31:0] H = 32'h1234_5678;
    localparam logic [31:0] L = 32'h9ABC_DEF0;

    typedef struct {
        logic [118:0] bus;
        logic         mo;
        logic         over;
        logic         wen;
        logic [4:0]   wd;
        logic [31:0]  wdata;
        logic         exc;
        logic [31:0]  epc;
        logic [31:0]  hi;
        logic [31:0]  lo;
    } vec_t;

    vec_t tbl[$];
    int checks = 0;
    int failures = 0;

    function automatic logic [118:0] mk(
        input logic        wen,
        input logic [4:0]  wd,
        input logic [31:0] mr,
        input logic [31:0] lr,
        input logic [5:0]  ctl,
        input logic [7:0]  addr,
        input logic [1:0]  se,
        input logic [31:0] pc
    );
        return {1'b0, wen, wd, mr, lr, ctl, addr, se, pc};
    endfunction

    task automatic add(
        input logic [118:0] bus, input logic mo, input logic over,
        input logic wen, input logic [4:0] wd, input logic [31:0] wdata,
        input logic exc, input logic [31:0] epc,
        input logic [31:0] hi, input logic [31:0] lo
    );
        vec_t v;
        v.bus = bus; v.mo = mo; v.over = over; v.wen = wen; v.wd = wd;
        v.wdata = wdata; v.exc = exc; v.epc = epc; v.hi = hi; v.lo = lo;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic step(input logic mo, input logic [118:0] bus);
        @(negedge clk);
        MEM_over   = mo;
        MEM_WB_bus = bus;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input int idx);
        chk("idle_over", idx, {31'b0, WB_over}, 32'h0);
        chk("idle_rf_wen", idx, {31'b0, rf_wen}, 32'h0);
        chk("idle_wb_wdest", idx, {27'b0, WB_wdest}, 32'h0);
        chk("idle_fwd_wdest", idx, {27'b0, fwd_wdest}, 32'h0);
        chk("idle_fwd_wdata", idx, fwd_wdata, 32'h0);
        chk("idle_rf_wdata", idx, rf_wdata, 32'h0);
        chk("idle_exc", idx, {31'b0, exc_valid}, 32'h0);
        chk("idle_cancel", idx, {31'b0, cancel}, 32'h0);
        chk("idle_exc_pc", idx, exc_pc, 32'h0);
        chk("idle_hi", idx, HI_data, 32'h0);
        chk("idle_lo", idx, LO_data, 32'h0);
        chk("idle_pc", idx, WB_pc, 32'h0);
        chk("idle_allow", idx, {31'b0, WB_allow_in}, 32'h1);
    endtask

    initial begin
        vec_t v;
        reset      = 1'b1;
        MEM_over   = 1'b0;
        MEM_WB_bus = '0;

        add(mk(0, 0, H, L, C_HW | C_LW, 8'h00, 2'b00, 32'h100), 1, 1, 0, 0, H, 0, 0, 0, 0);
        add(mk(1, 5, 0, 0, C_MFHI, 8'h00, 2'b00, 32'h104), 1, 1, 1, 5, H, 0, 0, H, L);
        add(mk(1, 6, 0, 0, C_MFLO, 8'h00, 2'b00, 32'h108), 1, 1, 1, 6, L, 0, 0, H, L);
        add(mk(0, 0, 32'hFFFF_FFFF, 0, C_MTC0, 8'h60, 2'b00, 32'h10C), 1, 1, 0, 0, 32'hFFFF_FFFF, 0, 0, H, L);
        add(mk(1, 1, 0, 0, C_MFC0, 8'h60, 2'b00, 32'h110), 1, 1, 1, 1, 32'h0000_FF03, 0, 0, H, L);
        add(mk(0, 0, 32'hAAAA_5555, 0, C_MTC0, 8'h08, 2'b00, 32'h114), 1, 1, 0, 0, 32'hAAAA_5555, 0, 0, H, L);
        add(mk(1, 2, 0, 0, C_MFC0, 8'h08, 2'b00, 32'h118), 1, 1, 1, 2, 32'h0, 0, 0, H, L);
        add(mk(1, 2, 0, 0, C_MFC0, 8'h68, 2'b00, 32'h11C), 1, 1, 1, 2, 32'h0, 0, 0, H, L);
        add(mk(0, 0, 32'h1, 0, C_MTC0, 8'h60, 2'b00, 32'h120), 1, 1, 0, 0, 32'h1, 0, 0, H, L);
        add(mk(0, 0, 0, 0, 6'b0, 8'h00, SE_SYS, 32'h40), 1, 1, 0, 0, 32'h0, 1, 32'h0, H, L);
        add(mk(1, 7, 32'hDEAD_BEEF, 0, 6'b0, 8'h00, 2'b00, 32'h44), 1, 0, 0, 7, 32'hDEAD_BEEF, 0, 0, H, L);
        add(mk(1, 3, 0, 0, C_MFC0, 8'h70, 2'b00, 32'h48), 1, 1, 1, 3, 32'h40, 0, 0, H, L);
        add(mk(1, 4, 0, 0, C_MFC0, 8'h60, 2'b00, 32'h4C), 1, 1, 1, 4, 32'h3, 0, 0, H, L);
        add(mk(1, 4, 0, 0, C_MFC0, 8'h68, 2'b00, 32'h50), 1, 1, 1, 4, 32'h20, 0, 0, H, L);
        add(mk(0, 0, 32'h100, 0, C_MTC0, 8'h70, 2'b00, 32'h54), 1, 1, 0, 0, 32'h100, 0, 0, H, L);
        add(mk(0, 0, 0, 0, 6'b0, 8'h00, SE_ERET, 32'h58), 1, 1, 0, 0, 32'h0, 1, 32'h100, H, L);
        add(mk(1, 8, 32'hCAFE_0001, 0, 6'b0, 8'h00, 2'b00, 32'h5C), 1, 0, 0, 8, 32'hCAFE_0001, 0, 0, H, L);
        add(mk(1, 9, 0, 0, C_MFC0, 8'h60, 2'b00, 32'h100), 1, 1, 1, 9, 32'h1, 0, 0, H, L);
        add(mk(1, 10, 0, 0, C_MFC0, 8'h70, 2'b00, 32'h104), 1, 1, 1, 10, 32'h100, 0, 0, H, L);
        add(mk(1, 3, 32'hFFFF_FF80, 0, 6'b0, 8'h00, 2'b00, 32'h108), 1, 1, 1, 3, 32'hFFFF_FF80, 0, 0, H, L);
        add(mk(0, 0, 0, 0, 6'b0, 8'h00, 2'b00, 32'h0), 0, 0, 0, 0, 32'h0, 0, 0, H, L);
        add(mk(0, 0, 32'hFFFF_FFFF, 0, C_MTC0, 8'h68, 2'b00, 32'h10C), 1, 1, 0, 0, 32'hFFFF_FFFF, 0, 0, H, L);
        add(mk(1, 11, 0, 0, C_MFC0, 8'h68, 2'b00, 32'h110), 1, 1, 1, 11, 32'h37C, 0, 0, H, L);
        add(mk(1, 12, 32'h5, 32'h6, C_HW | C_LW | C_MFHI, 8'h00, 2'b00, 32'h114), 1, 1, 1, 12, H, 0, 0, H, L);
        add(mk(1, 13, 0, 0, C_MFHI, 8'h00, 2'b00, 32'h118), 1, 1, 1, 13, 32'h5, 0, 0, 32'h5, 32'h6);

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_idle(-1);

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            step(v.mo, v.bus);
            chk("over", i, {31'b0, WB_over}, {31'b0, v.over});
            chk("rf_wen", i, {31'b0, rf_wen}, {31'b0, v.wen});
            chk("rf_wdest", i, {27'b0, rf_wdest}, {27'b0, v.wd});
            chk("rf_wdata", i, rf_wdata, v.wdata);
            chk("wb_wdest", i, {27'b0, WB_wdest}, v.over ? {27'b0, v.wd} : 32'h0);
            chk("fwd_wdest", i, {27'b0, fwd_wdest}, v.over ? {27'b0, v.wd} : 32'h0);
            chk("fwd_wdata", i, fwd_wdata, v.over ? v.wdata : 32'h0);
            chk("exc_valid", i, {31'b0, exc_valid}, {31'b0, v.exc});
            chk("cancel", i, {31'b0, cancel}, {31'b0, v.exc});
            chk("exc_pc", i, exc_pc, v.epc);
            chk("hi", i, HI_data, v.hi);
            chk("lo", i, LO_data, v.lo);
            chk("wb_pc", i, WB_pc, v.bus[31:0]);
        end

        step(1'b1, mk(0, 0, 0, 0, 6'b0, 8'h00, SE_SYS, 32'h200));
        chk("rst_pre_exc", 100, {31'b0, exc_valid}, 32'h1);
        @(negedge clk);
        MEM_over = 1'b0;
        reset    = 1'b1;
        #1;
        chk("rst_exc", 101, {31'b0, exc_valid}, 32'h0);
        chk("rst_cancel", 101, {31'b0, cancel}, 32'h0);
        chk("rst_exc_pc", 101, exc_pc, 32'h0);
        chk("rst_rf_wen", 101, {31'b0, rf_wen}, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_idle(102);

        step(1'b1, mk(1, 1, 0, 0, C_MFC0, 8'h70, 2'b00, 32'h300));
        chk("rst_epc", 103, rf_wdata, 32'h0);
        step(1'b1, mk(1, 1, 0, 0, C_MFC0, 8'h60, 2'b00, 32'h304));
        chk("rst_status", 104, rf_wdata, 32'h0);
        step(1'b1, mk(1, 1, 0, 0, C_MFC0, 8'h68, 2'b00, 32'h308));
        chk("rst_cause", 105, rf_wdata, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
